// File: rtl/lenet_pkg.sv
// ============================================================================
// Module      : lenet_pkg
// Description : Shared LeNet types and frame geometry for the image path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lenet_pkg;

    localparam int BITWIDTH     = 8;
    localparam int IMG_DIM      = 28;
    localparam int FRAME_PIXELS = IMG_DIM * IMG_DIM;

    typedef logic signed [BITWIDTH-1:0]        pixel_t;
    typedef pixel_t [IMG_DIM-1:0][IMG_DIM-1:0] image_t;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_HOLD = 1'b1
    } ld_state_t;

    // pix_last must coincide exactly with the final raster position
    function automatic logic framing_error(input logic last, input logic at_last);
        return last ^ at_last;
    endfunction

endpackage

`default_nettype wire

// File: rtl/image_frame_loader_raster_counter.sv
// ============================================================================
// Module      : raster_counter
// Description : Row/column raster position for the frame loader write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_counter #(
    parameter int IMG_DIM = 28,
    parameter int CNT_W   = $clog2(IMG_DIM)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             at_last
);
    import lenet_pkg::*;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(IMG_DIM - 1);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == c_last) begin
                col_d = '0;
                row_d = (row_q == c_last) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign at_last = (row_q == c_last) && (col_q == c_last);

endmodule

`default_nettype wire

// File: rtl/image_frame_loader.sv
// ============================================================================
// Module      : image_frame_loader
// Description : Assembles a raster pixel stream into the 28x28 LeNet frame and
//               publishes it with a frame_valid/frame_ack handshake.
//               Define IMAGE_FRAME_LOADER_PINGPONG_EN for a double-buffered
//               build; the default is a single LOAD/HOLD bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_frame_loader #(
    parameter int BITWIDTH = 8,
    parameter int IMG_DIM  = 28
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         pix_valid,
    output logic                                         pix_ready,
    input  logic [BITWIDTH-1:0]                          pix_data,
    input  logic                                         pix_last,
    output logic [IMG_DIM-1:0][IMG_DIM-1:0][BITWIDTH-1:0] image,
    output logic                                         frame_valid,
    input  logic                                         frame_ack,
    output logic [7:0]                                   frame_cnt,
    output logic                                         frame_err,
    input  logic                                         err_clr
);
    import lenet_pkg::*;

    localparam int CNT_W = $clog2(IMG_DIM);

    logic [CNT_W-1:0] row, col;
    logic             at_last;
    logic             xfer, done, bad;

    logic       pix_ready_q,   pix_ready_d;
    logic       frame_valid_q, frame_valid_d;
    logic       frame_err_q,   frame_err_d;
    logic [7:0] frame_cnt_q,   frame_cnt_d;

    assign xfer = pix_valid && pix_ready_q;
    assign done = xfer && at_last;
    assign bad  = xfer && framing_error(pix_last, at_last);

    // Early pix_last drops the partial frame by rewinding the raster
    raster_counter #(
        .IMG_DIM (IMG_DIM)
    ) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (xfer && pix_last && !at_last),
        .advance (xfer),
        .row     (row),
        .col     (col),
        .at_last (at_last)
    );

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (done) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        frame_err_d = frame_err_q;
        if (err_clr) begin
            frame_err_d = 1'b0;
        end
        if (bad) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_ready_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            pix_ready_q   <= pix_ready_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
    image_t     bank_q [2];
    image_t     bank_d [2];
    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;

    // A completing write and a consumer ack never target the same bank
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (xfer) begin
            bank_d[wr_bank_q][row][col] = pixel_t'(pix_data);
        end
        if (done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
        if (frame_ack && frame_valid_q) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
        pix_ready_d   = !full_d[wr_bank_d];
        frame_valid_d = full_d[rd_bank_d];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    assign image = bank_q[rd_bank_q];
`else
    image_t    frame_buf_q, frame_buf_d;
    ld_state_t state_q, state_d;

    always_comb begin
        frame_buf_d = frame_buf_q;
        state_d     = state_q;
        if (xfer) begin
            frame_buf_d[row][col] = pixel_t'(pix_data);
        end
        case (state_q)
            ST_LOAD: if (done)      state_d = ST_HOLD;
            ST_HOLD: if (frame_ack) state_d = ST_LOAD;
            default:                state_d = ST_LOAD;
        endcase
        pix_ready_d   = (state_d == ST_LOAD);
        frame_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_buf_q <= '0;
            state_q     <= ST_LOAD;
        end else begin
            frame_buf_q <= frame_buf_d;
            state_q     <= state_d;
        end
    end

    assign image = frame_buf_q;
`endif

    assign pix_ready   = pix_ready_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_image_frame_loader.sv
// ============================================================================
// Module      : tb_image_frame_loader
// Description : Scoreboard bench for image_frame_loader (either bank build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_frame_loader;
    import lenet_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] pix_data = '0;
    logic       pix_last = 1'b0;
    logic [27:0][27:0][7:0] image;
    logic       frame_valid;
    logic       frame_ack = 1'b0;
    logic [7:0] frame_cnt;
    logic       frame_err;
    logic       err_clr = 1'b0;

    int     n_checks = 0;
    int     n_errors = 0;
    int     exp_cnt  = 0;
    image_t sb [$];
    image_t snap;
    logic   prev_valid = 1'b0;

    image_frame_loader #(
        .BITWIDTH (8),
        .IMG_DIM  (28)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .image       (image),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_cnt   (frame_cnt),
        .frame_err   (frame_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int idx, input int seed);
        if (seed == 0) return 8'(idx % 128);
        return 8'(idx * seed + seed * 3);
    endfunction

    function automatic int n_diff(input image_t a, input image_t b);
        int n = 0;
        for (int r = 0; r < IMG_DIM; r++)
            for (int c = 0; c < IMG_DIM; c++)
                if (a[r][c] !== b[r][c]) n++;
        return n;
    endfunction

    // Every time a new frame becomes visible, compare it with the oldest expected one
    always begin
        image_t e;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (frame_valid && (!prev_valid || frame_ack)) begin
                if (sb.size() == 0) begin
                    check("pub_expected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("frame_pixels_diff", n_diff(image, e), 0);
                end
            end
            prev_valid = frame_valid;
        end
    end

    task automatic stream(input int n, input int last_at, input int seed,
                          input bit gap, input bit clr_on_last);
        int     idx = 0;
        int     cyc = 0;
        bit     rise_chk;
        image_t e;
        rise_chk = (n == FRAME_PIXELS) && (frame_valid == 1'b0);
        if (n == FRAME_PIXELS) begin
            for (int i = 0; i < FRAME_PIXELS; i++)
                e[i / IMG_DIM][i % IMG_DIM] = pix_val(i, seed);
            sb.push_back(e);
        end
        while (idx < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (gap && $urandom_range(0, 1) == 0) begin
                pix_valid = 1'b0;
                pix_last  = 1'b0;
                err_clr   = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data  = pix_val(idx, seed);
                pix_last  = (idx == last_at);
                err_clr   = clr_on_last && (idx == last_at);
                if (pix_ready) begin
                    if (rise_chk && idx == FRAME_PIXELS - 1)
                        check("fv_before_final", frame_valid, 0);
                    idx++;
                end
            end
        end
        check("beats_accepted", idx, n);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        err_clr   = 1'b0;
        if (rise_chk) check("fv_on_final", frame_valid, 1);
    endtask

    task automatic ack(input logic exp_fv);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("fv_after_ack", frame_valid, exp_fv);
        check("rdy_after_ack", pix_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        image_t zero = '0;
        #12;
        check("rst_ready", pix_ready, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_err", frame_err, 0);
        check("rst_image", n_diff(image, zero), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", pix_ready, 1);

        // Normal load
        stream(FRAME_PIXELS, FRAME_PIXELS - 1, 0, 1'b0, 1'b0);
        exp_cnt++;
        check("norm_px_0_5", image[0][5], 5);
        check("norm_px_1_0", image[1][0], 28);
        check("norm_px_27_27", image[27][27], 15);
        check("norm_cnt", frame_cnt, exp_cnt);
        check("norm_err", frame_err, 0);
        snap = image;

`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
        // Frame B loads into the spare bank while A is still presented
        stream(FRAME_PIXELS, FRAME_PIXELS - 1, 3, 1'b0, 1'b0);
        exp_cnt++;
        check("pp_fv_held", frame_valid, 1);
        check("pp_image_is_a", n_diff(image, snap), 0);
        check("pp_cnt_b", frame_cnt, exp_cnt);
        check("pp_both_full", pix_ready, 0);
        ack(1'b1);
        stream(FRAME_PIXELS, FRAME_PIXELS - 1, 5, 1'b0, 1'b0);
        exp_cnt++;
        check("pp_cnt_c", frame_cnt, exp_cnt);
        ack(1'b1);
        ack(1'b0);
`else
        // Backpressure while the frame is held
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = 8'h55;
            pix_last  = 1'b1;
            check("bp_ready", pix_ready, 0);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        check("bp_image_hold", n_diff(image, snap), 0);
        check("bp_cnt", frame_cnt, exp_cnt);
        ack(1'b0);
`endif
        ack(1'b0);

        // Early pix_last, with err_clr on the same beat: the error must win
        stream(101, 100, 7, 1'b0, 1'b1);
        check("early_err", frame_err, 1);
        check("early_no_pub", frame_valid, 0);
        check("early_cnt", frame_cnt, exp_cnt);
        stream(FRAME_PIXELS, FRAME_PIXELS - 1, 9, 1'b0, 1'b0);
        exp_cnt++;
        check("after_early_cnt", frame_cnt, exp_cnt);
        check("err_sticky", frame_err, 1);
        ack(1'b0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", frame_err, 0);

        // Gapped source reproduces the first frame
        stream(FRAME_PIXELS, FRAME_PIXELS - 1, 0, 1'b1, 1'b0);
        exp_cnt++;
        check("gap_cnt", frame_cnt, exp_cnt);
        ack(1'b0);

        // Final pixel without pix_last: error but still published
        stream(FRAME_PIXELS, -1, 11, 1'b0, 1'b0);
        exp_cnt++;
        check("miss_last_err", frame_err, 1);
        check("miss_last_cnt", frame_cnt, exp_cnt);
        ack(1'b0);

        // Asynchronous reset in the middle of a frame
        stream(400, -1, 13, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", pix_ready, 0);
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_cnt", frame_cnt, 0);
        check("mid_rst_err", frame_err, 0);
        check("mid_rst_image", n_diff(image, zero), 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        stream(FRAME_PIXELS, FRAME_PIXELS - 1, 13, 1'b0, 1'b0);
        exp_cnt++;
        check("post_rst_cnt", frame_cnt, exp_cnt);
        check("post_rst_err", frame_err, 0);
        ack(1'b0);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
